// File: rtl/fsm_bus_pkg.sv
// Shared types and widths for the FLASH/SRAM bus arbiter.
package fsm_bus_pkg;

   localparam int FSM_AW   = 26;
   localparam int FSM_DW   = 32;
   localparam int FLASH_DW = 16;
   localparam int FLASH_AW = 24;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_HOLD   = 3'd3,
      ST_TURN   = 3'd4
   } state_e;

   typedef enum logic {
      CL_FLASH = 1'b0,
      CL_SRAM  = 1'b1
   } client_e;

endpackage

// File: rtl/fsm_rr_arb.sv
// Two-way round-robin grant. The grant is combinational from the valids and
// the pointer; the pointer moves to the loser whenever a grant is taken.
module fsm_rr_arb
   import fsm_bus_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       f_valid_i,
   input  logic       s_valid_i,
   input  logic       adv_i,
   output logic [1:0] gnt_o
);

   client_e ptr_q, ptr_d;

   // One-hot grant: bit0 = flash, bit1 = SRAM; a lone requester always wins.
   always_comb begin
      gnt_o = 2'b00;
      if (f_valid_i && s_valid_i) begin
         gnt_o = (ptr_q == CL_FLASH) ? 2'b01 : 2'b10;
      end else if (f_valid_i) begin
         gnt_o = 2'b01;
      end else if (s_valid_i) begin
         gnt_o = 2'b10;
      end
   end

   // Pointer update: favour the client that did not win.
   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         if (gnt_o[0]) begin
            ptr_d = CL_SRAM;
         end else if (gnt_o[1]) begin
            ptr_d = CL_FLASH;
         end
      end
   end

   // Pointer register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q <= CL_FLASH;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fsm_bus_arb.sv
// Arbiter and strobe sequencer for the shared FLASH/SRAM bus.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | bus free; a grant is registered as a one-cycle ready pulse
// ST_SETUP  | address and chip enable out, write data driven for writes
// ST_ACCESS | oe_n or we_n low for WS+1 cycles; read data sampled on last
// ST_HOLD   | strobes released, ce/addr/data held, response pulse
// ST_TURN   | all strobes high, pads released for TURN_CYC cycles
//
// The grant decision is taken on the edge that enters (or stays in) IDLE, so
// the registered ready is already high in the first IDLE cycle. The client
// chosen there stays in cl_q for the whole access.
module fsm_bus_arb
   import fsm_bus_pkg::*;
#(
   parameter int unsigned FLASH_WS = 7,
   parameter int unsigned SRAM_WS  = 1,
   parameter int unsigned TURN_CYC = 1
)
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  f_req_valid,
   output logic                  f_req_ready,
   input  logic                  f_req_write,
   input  logic [FLASH_AW-1:0]   f_req_addr,
   input  logic [FLASH_DW-1:0]   f_req_wdata,
   output logic                  f_rsp_valid,
   output logic [FLASH_DW-1:0]   f_rsp_rdata,
   input  logic                  s_req_valid,
   output logic                  s_req_ready,
   input  logic                  s_req_write,
   input  logic [FSM_AW-1:0]     s_req_addr,
   input  logic [FSM_DW-1:0]     s_req_wdata,
   output logic                  s_rsp_valid,
   output logic [FSM_DW-1:0]     s_rsp_rdata,
   output logic [FSM_AW-1:0]     fsm_a,
   output logic [FSM_DW-1:0]     fsm_d_o,
   output logic                  fsm_d_oe,
   input  logic [FSM_DW-1:0]     fsm_d_i,
   output logic                  flash_ce_n,
   output logic                  flash_oe_n,
   output logic                  flash_we_n,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n
);

   localparam logic [3:0] FWS      = 4'(FLASH_WS);
   localparam logic [3:0] SWS      = 4'(SRAM_WS);
   localparam logic [3:0] TRN_LAST = (TURN_CYC == 0) ? 4'd0 : 4'(TURN_CYC - 1);

   state_e                state_q, state_d;
   client_e               cl_q, cl_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic [1:0]            gnt;
   logic                  accept;
   logic                  decide;
   logic                  last_acc;
   logic [3:0]            ws_cur;

   logic                  f_rdy_q, f_rdy_d;
   logic                  s_rdy_q, s_rdy_d;
   logic                  f_rsp_q, f_rsp_d;
   logic                  s_rsp_q, s_rsp_d;
   logic [FLASH_DW-1:0]   f_rd_q, f_rd_d;
   logic [FSM_DW-1:0]     s_rd_q, s_rd_d;
   logic [FSM_AW-1:0]     a_q, a_d;
   logic [FSM_DW-1:0]     do_q, do_d;
   logic                  oe_q, oe_d;
   logic                  fce_q, fce_d, foe_q, foe_d, fwe_q, fwe_d;
   logic                  sce_q, sce_d, soe_q, soe_d, swe_q, swe_d;

   fsm_rr_arb u_arb (
      .CLK       (CLK),
      .RST       (RST),
      .f_valid_i (f_req_valid),
      .s_valid_i (s_req_valid),
      .adv_i     (decide),
      .gnt_o     (gnt)
   );

   assign accept   = (state_q == ST_IDLE) &&
                     ((f_rdy_q && f_req_valid) || (s_rdy_q && s_req_valid));
   assign ws_cur   = (cl_q == CL_FLASH) ? FWS : SWS;
   assign last_acc = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

   // Next-state and wait-state / turnaround down-counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            cnt_d   = ws_cur;
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (TURN_CYC == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_TURN;
               cnt_d   = TRN_LAST;
            end
         end
         ST_TURN: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output next values, all derived from the upcoming state.
   always_comb begin
      decide  = (state_d == ST_IDLE) && (gnt != 2'b00);
      f_rdy_d = decide && gnt[0];
      s_rdy_d = decide && gnt[1];
      cl_d    = cl_q;
      if (decide) begin
         cl_d = gnt[1] ? CL_SRAM : CL_FLASH;
      end

      wr_d = wr_q;
      a_d  = a_q;
      do_d = do_q;
      if (accept) begin
         if (cl_q == CL_FLASH) begin
            wr_d = f_req_write;
            a_d  = {2'b00, f_req_addr};
            do_d = f_req_write ? {16'h0000, f_req_wdata} : '0;
         end else begin
            wr_d = s_req_write;
            a_d  = s_req_addr;
            do_d = s_req_write ? s_req_wdata : '0;
         end
      end

      fce_d = !((state_d inside {ST_SETUP, ST_ACCESS, ST_HOLD}) && (cl_q == CL_FLASH));
      sce_d = !((state_d inside {ST_SETUP, ST_ACCESS, ST_HOLD}) && (cl_q == CL_SRAM));
      foe_d = !((state_d == ST_ACCESS) && (cl_q == CL_FLASH) && !wr_d);
      fwe_d = !((state_d == ST_ACCESS) && (cl_q == CL_FLASH) && wr_d);
      soe_d = !((state_d == ST_ACCESS) && (cl_q == CL_SRAM) && !wr_d);
      swe_d = !((state_d == ST_ACCESS) && (cl_q == CL_SRAM) && wr_d);
      oe_d  = (state_d inside {ST_SETUP, ST_ACCESS, ST_HOLD}) && wr_d;

      f_rsp_d = last_acc && (cl_q == CL_FLASH);
      s_rsp_d = last_acc && (cl_q == CL_SRAM);
      f_rd_d  = f_rd_q;
      s_rd_d  = s_rd_q;
      if (last_acc && !wr_q) begin
         if (cl_q == CL_FLASH) begin
            f_rd_d = fsm_d_i[FLASH_DW-1:0];
         end else begin
            s_rd_d = fsm_d_i;
         end
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         cl_q    <= CL_FLASH;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cl_q    <= cl_d;
         wr_q    <= wr_d;
      end
   end

   // Output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         f_rdy_q <= 1'b0;
         s_rdy_q <= 1'b0;
         f_rsp_q <= 1'b0;
         s_rsp_q <= 1'b0;
         f_rd_q  <= '0;
         s_rd_q  <= '0;
         a_q     <= '0;
         do_q    <= '0;
         oe_q    <= 1'b0;
         fce_q   <= 1'b1;
         foe_q   <= 1'b1;
         fwe_q   <= 1'b1;
         sce_q   <= 1'b1;
         soe_q   <= 1'b1;
         swe_q   <= 1'b1;
      end else begin
         f_rdy_q <= f_rdy_d;
         s_rdy_q <= s_rdy_d;
         f_rsp_q <= f_rsp_d;
         s_rsp_q <= s_rsp_d;
         f_rd_q  <= f_rd_d;
         s_rd_q  <= s_rd_d;
         a_q     <= a_d;
         do_q    <= do_d;
         oe_q    <= oe_d;
         fce_q   <= fce_d;
         foe_q   <= foe_d;
         fwe_q   <= fwe_d;
         sce_q   <= sce_d;
         soe_q   <= soe_d;
         swe_q   <= swe_d;
      end
   end

   assign f_req_ready = f_rdy_q;
   assign s_req_ready = s_rdy_q;
   assign f_rsp_valid = f_rsp_q;
   assign s_rsp_valid = s_rsp_q;
   assign f_rsp_rdata = f_rd_q;
   assign s_rsp_rdata = s_rd_q;
   assign fsm_a       = a_q;
   assign fsm_d_o     = do_q;
   assign fsm_d_oe    = oe_q;
   assign flash_ce_n  = fce_q;
   assign flash_oe_n  = foe_q;
   assign flash_we_n  = fwe_q;
   assign sram_ce_n   = sce_q;
   assign sram_oe_n   = soe_q;
   assign sram_we_n   = swe_q;

endmodule

// File: tb/tb_fsm_bus_arb.sv
// Bench for fsm_bus_arb: default build plus a TURN_CYC=0 / SRAM_WS=0 build.
module tb_fsm_bus_arb;

   localparam int FWS = 7;
   localparam int SWS = 1;

   typedef struct {
      logic [31:0] rd;
      int          at;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // default build
   logic        f_req_valid, f_req_ready, f_req_write, f_rsp_valid;
   logic [23:0] f_req_addr;
   logic [15:0] f_req_wdata, f_rsp_rdata;
   logic        s_req_valid, s_req_ready, s_req_write, s_rsp_valid;
   logic [25:0] s_req_addr;
   logic [31:0] s_req_wdata, s_rsp_rdata;
   logic [25:0] fsm_a;
   logic [31:0] fsm_d_o, fsm_d_i;
   logic        fsm_d_oe;
   logic        flash_ce_n, flash_oe_n, flash_we_n, sram_ce_n, sram_oe_n, sram_we_n;

   // fast build
   logic        b_f_req_valid, b_f_req_ready, b_f_req_write, b_f_rsp_valid;
   logic [23:0] b_f_req_addr;
   logic [15:0] b_f_req_wdata, b_f_rsp_rdata;
   logic        b_s_req_valid, b_s_req_ready, b_s_req_write, b_s_rsp_valid;
   logic [25:0] b_s_req_addr;
   logic [31:0] b_s_req_wdata, b_s_rsp_rdata;
   logic [25:0] b_fsm_a;
   logic [31:0] b_fsm_d_o, b_fsm_d_i;
   logic        b_fsm_d_oe;
   logic        b_flash_ce_n, b_flash_oe_n, b_flash_we_n, b_sram_ce_n, b_sram_oe_n, b_sram_we_n;

   fsm_bus_arb #(.FLASH_WS(FWS), .SRAM_WS(SWS), .TURN_CYC(1)) dut (
      .CLK(clk), .RST(rst),
      .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_write(f_req_write),
      .f_req_addr(f_req_addr), .f_req_wdata(f_req_wdata),
      .f_rsp_valid(f_rsp_valid), .f_rsp_rdata(f_rsp_rdata),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_write(s_req_write),
      .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
      .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
      .fsm_a(fsm_a), .fsm_d_o(fsm_d_o), .fsm_d_oe(fsm_d_oe), .fsm_d_i(fsm_d_i),
      .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   fsm_bus_arb #(.FLASH_WS(FWS), .SRAM_WS(0), .TURN_CYC(0)) dut2 (
      .CLK(clk), .RST(rst),
      .f_req_valid(b_f_req_valid), .f_req_ready(b_f_req_ready), .f_req_write(b_f_req_write),
      .f_req_addr(b_f_req_addr), .f_req_wdata(b_f_req_wdata),
      .f_rsp_valid(b_f_rsp_valid), .f_rsp_rdata(b_f_rsp_rdata),
      .s_req_valid(b_s_req_valid), .s_req_ready(b_s_req_ready), .s_req_write(b_s_req_write),
      .s_req_addr(b_s_req_addr), .s_req_wdata(b_s_req_wdata),
      .s_rsp_valid(b_s_rsp_valid), .s_rsp_rdata(b_s_rsp_rdata),
      .fsm_a(b_fsm_a), .fsm_d_o(b_fsm_d_o), .fsm_d_oe(b_fsm_d_oe), .fsm_d_i(b_fsm_d_i),
      .flash_ce_n(b_flash_ce_n), .flash_oe_n(b_flash_oe_n), .flash_we_n(b_flash_we_n),
      .sram_ce_n(b_sram_ce_n), .sram_oe_n(b_sram_oe_n), .sram_we_n(b_sram_we_n)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t fq[$];
   exp_t sq[$];
   exp_t s2q[$];
   int   acc_cl[$];
   int   acc_t[$];
   logic chk_en = 1'b0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   function automatic void fail_now(string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endfunction

   // Scoreboard monitors: pop one expectation per response pulse.
   always @(negedge clk) begin
      exp_t e;
      if (chk_en && f_rsp_valid) begin
         if (fq.size() == 0) fail_now("f_rsp_unexpected");
         else begin
            e = fq.pop_front();
            check("f_rsp_rdata", f_rsp_rdata, e.rd);
            check("f_rsp_cycle", cyc, e.at);
         end
      end
      if (chk_en && s_rsp_valid) begin
         if (sq.size() == 0) fail_now("s_rsp_unexpected");
         else begin
            e = sq.pop_front();
            check("s_rsp_rdata", s_rsp_rdata, e.rd);
            check("s_rsp_cycle", cyc, e.at);
         end
      end
      if (chk_en && b_s_rsp_valid) begin
         if (s2q.size() == 0) fail_now("s2_rsp_unexpected");
         else begin
            e = s2q.pop_front();
            check("s2_rsp_rdata", b_s_rsp_rdata, e.rd);
            check("s2_rsp_cycle", cyc, e.at);
         end
      end
   end

   // Bus invariants, including a strobe-free gap between different devices.
   logic prev_f, prev_s;
   always @(negedge clk) begin
      logic bad;
      if (chk_en) begin
         bad = (!flash_ce_n && !sram_ce_n) ||
               (!flash_oe_n && !flash_we_n) || (!sram_oe_n && !sram_we_n) ||
               (fsm_d_oe && !((!flash_ce_n || !sram_ce_n) && flash_oe_n && sram_oe_n)) ||
               (prev_f && !sram_ce_n) || (prev_s && !flash_ce_n) ||
               (!b_flash_ce_n && !b_sram_ce_n);
         check("bus_invariants", {31'd0, bad}, 32'd0);
      end
      prev_f = !flash_ce_n;
      prev_s = !sram_ce_n;
   end

   task automatic drv_f(input logic wr, input logic [23:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input bit push, output int t_acc);
      f_req_valid = 1'b1; f_req_write = wr; f_req_addr = a; f_req_wdata = wd;
      t_acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (f_req_ready) begin
            t_acc = cyc;
            break;
         end
      end
      if (t_acc < 0) begin
         fail_now("f_accept_timeout");
         f_req_valid = 1'b0;
      end else begin
         if (push) fq.push_back('{{16'h0, exp_rd}, t_acc + FWS + 3});
         acc_cl.push_back(0);
         acc_t.push_back(t_acc);
         @(posedge clk);
         #1 f_req_valid = 1'b0;
      end
   endtask

   task automatic drv_s(input logic wr, input logic [25:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, output int t_acc);
      s_req_valid = 1'b1; s_req_write = wr; s_req_addr = a; s_req_wdata = wd;
      t_acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_req_ready) begin
            t_acc = cyc;
            break;
         end
      end
      if (t_acc < 0) begin
         fail_now("s_accept_timeout");
         s_req_valid = 1'b0;
      end else begin
         sq.push_back('{exp_rd, t_acc + SWS + 3});
         acc_cl.push_back(1);
         acc_t.push_back(t_acc);
         @(posedge clk);
         #1 s_req_valid = 1'b0;
      end
   endtask

   task automatic drv_s2(input logic [25:0] a, input logic [31:0] exp_rd, output int t_acc);
      b_s_req_valid = 1'b1; b_s_req_write = 1'b0; b_s_req_addr = a; b_s_req_wdata = '0;
      t_acc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (b_s_req_ready) begin
            t_acc = cyc;
            break;
         end
      end
      if (t_acc < 0) begin
         fail_now("s2_accept_timeout");
         b_s_req_valid = 1'b0;
      end else begin
         s2q.push_back('{exp_rd, t_acc + 3});
         @(posedge clk);
         #1 b_s_req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((fq.size() != 0 || sq.size() != 0 || s2q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) fail_now("drain_timeout");
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, t2, t3, t0, oe_lo;
      int exp_cl[6];
      int exp_gap[5];
      exp_cl  = '{0, 1, 0, 1, 0, 1};
      exp_gap = '{12, 6, 12, 6, 12};

      rst = 1'b1;
      f_req_valid = 0; f_req_write = 0; f_req_addr = '0; f_req_wdata = '0;
      s_req_valid = 0; s_req_write = 0; s_req_addr = '0; s_req_wdata = '0;
      b_f_req_valid = 0; b_f_req_write = 0; b_f_req_addr = '0; b_f_req_wdata = '0;
      b_s_req_valid = 0; b_s_req_write = 0; b_s_req_addr = '0; b_s_req_wdata = '0;
      fsm_d_i = '0; b_fsm_d_i = '0;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_flash_ce_n", flash_ce_n, 1);
      check("rst_flash_oe_n", flash_oe_n, 1);
      check("rst_flash_we_n", flash_we_n, 1);
      check("rst_sram_ce_n", sram_ce_n, 1);
      check("rst_sram_oe_n", sram_oe_n, 1);
      check("rst_sram_we_n", sram_we_n, 1);
      check("rst_fsm_d_oe", fsm_d_oe, 0);
      check("rst_fsm_a", fsm_a, 0);
      check("rst_fsm_d_o", fsm_d_o, 0);
      check("rst_f_req_ready", f_req_ready, 0);
      check("rst_s_req_ready", s_req_ready, 0);
      check("rst_f_rsp_valid", f_rsp_valid, 0);
      check("rst_s_rsp_valid", s_rsp_valid, 0);
      check("rst_f_rsp_rdata", f_rsp_rdata, 0);
      check("rst_s_rsp_rdata", s_rsp_rdata, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // flash read 0x000123, rdata 0xBEEF at T+10, next accept at T+12
      fsm_d_i = 32'hDEAD_BEEF;
      drv_f(1'b0, 24'h000123, 16'h0, 16'hBEEF, 1'b1, t1);
      oe_lo = 0;
      fork
         begin
            for (int k = 1; k <= 11; k++) begin
               @(negedge clk);
               if (k == 1) check("flash_rd_fsm_a", fsm_a, 32'h0000123);
               check("flash_rd_oe_n", flash_oe_n, (k >= 2 && k <= 9) ? 1'b0 : 1'b1);
               if (!flash_oe_n) oe_lo++;
            end
            check("flash_rd_oe_low_cycles", oe_lo, 8);
         end
         drv_f(1'b0, 24'h000456, 16'h0, 16'hBEEF, 1'b1, t2);
      join
      check("flash_next_accept", t2, t1 + 12);

      // SRAM write 0x3FFFFFF / 0xA5A55A5A
      drv_s(1'b1, 26'h3FFFFFF, 32'hA5A5_5A5A, 32'h0, t3);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("sram_wr_fsm_a", fsm_a, 32'h3FFFFFF);
            check("sram_wr_fsm_d_o", fsm_d_o, 32'hA5A5_5A5A);
         end
         check("sram_wr_we_n", sram_we_n, (k == 2 || k == 3) ? 1'b0 : 1'b1);
         check("sram_wr_oe_n", sram_oe_n, 1'b1);
         check("sram_wr_d_oe", fsm_d_oe, (k <= 4) ? 1'b1 : 1'b0);
      end

      // SRAM read, then flash write (flash rdata keeps 0xBEEF)
      fsm_d_i = 32'h1357_9BDF;
      drv_s(1'b0, 26'h0000010, 32'h0, 32'h1357_9BDF, t3);
      drv_f(1'b1, 24'hABCDEF, 16'h7E57, 16'hBEEF, 1'b1, t1);
      @(negedge clk);
      check("flash_wr_fsm_a", fsm_a, 32'h0ABCDEF);
      check("flash_wr_fsm_d_o", fsm_d_o, 32'h0000_7E57);
      check("flash_wr_d_oe", fsm_d_oe, 1'b1);
      drain();

      // both clients continuously valid: F,S,F,S,F,S
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      fsm_d_i = 32'h0F0F_F0F0;
      acc_cl.delete();
      acc_t.delete();
      fork
         begin
            drv_f(1'b0, 24'h000010, 16'h0, 16'hF0F0, 1'b1, t1);
            drv_f(1'b0, 24'h000020, 16'h0, 16'hF0F0, 1'b1, t1);
            drv_f(1'b0, 24'h000030, 16'h0, 16'hF0F0, 1'b1, t1);
         end
         begin
            drv_s(1'b0, 26'h0000100, 32'h0, 32'h0F0F_F0F0, t2);
            drv_s(1'b1, 26'h0000200, 32'h1111_2222, 32'h0F0F_F0F0, t2);
            drv_s(1'b0, 26'h0000300, 32'h0, 32'h0F0F_F0F0, t2);
         end
      join
      check("alt_accept_count", acc_cl.size(), 6);
      if (acc_cl.size() == 6) begin
         for (int i = 0; i < 6; i++) check($sformatf("alt_grant_%0d", i), acc_cl[i], exp_cl[i]);
         for (int i = 0; i < 5; i++)
            check($sformatf("alt_gap_%0d", i), acc_t[i+1] - acc_t[i], exp_gap[i]);
      end
      drain();

      // only SRAM valid, pointer at flash
      t0 = cyc;
      drv_s(1'b0, 26'h0000040, 32'h0, 32'h0F0F_F0F0, t2);
      check("sram_only_grant", t2, t0 + 1);
      drain();

      // reset during flash ACCESS: no response, next request normal
      drv_f(1'b0, 24'h000777, 16'h0, 16'h0, 1'b0, t1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("abort_in_access", flash_oe_n, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_flash_ce_n", flash_ce_n, 1);
      check("abort_flash_oe_n", flash_oe_n, 1);
      check("abort_sram_ce_n", sram_ce_n, 1);
      check("abort_fsm_d_oe", fsm_d_oe, 0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("abort_no_rsp", f_rsp_valid, 0);
      end
      fsm_d_i = 32'hCAFE_1234;
      @(posedge clk);
      #1;
      drv_f(1'b0, 24'h000888, 16'h0, 16'h1234, 1'b1, t1);
      drain();

      // fast build: back-to-back SRAM reads every 4 cycles, rsp at +3
      b_fsm_d_i = 32'h55AA_33CC;
      drv_s2(26'h0000001, 32'h55AA_33CC, t1);
      drv_s2(26'h0000002, 32'h55AA_33CC, t2);
      check("fast_gap_0", t2 - t1, 4);
      drv_s2(26'h0000003, 32'h55AA_33CC, t3);
      check("fast_gap_1", t3 - t2, 4);
      drain();

      check("queues_empty", fq.size() + sq.size() + s2q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fsm_bus_arb.md
Name: fsm_bus_arb

Overview:
- Arbiter and sequencer for the shared FLASH/SRAM bus: one address bus fsm_a[25:0] and one bidirectional data bus fsm_d[31:0].
- Two requesters: a 16-bit flash client (port f_*) and a 32-bit SRAM client (port s_*).
- Grants the bus round-robin and generates chip-enable, output-enable and write-enable strobes with per-device wait states.
- Inserts a bus-turnaround gap between accesses. Sits between the flash/SRAM controller logic and the pad-level tristate buffers in the board top.

Parameters:
- FLASH_WS, 7, extra ACCESS cycles for flash (ACCESS phase lasts FLASH_WS+1 cycles); range 0..15
- SRAM_WS, 1, extra ACCESS cycles for SRAM; range 0..15
- TURN_CYC, 1, idle cycles after every access with all strobes deasserted; 0 means no TURN state

Ports:
- CLK  in  1  single clock for all logic
- RST  in  1  synchronous, active-high reset
- f_req_valid  in  1  flash request valid
- f_req_ready  out  1  flash request accepted this cycle
- f_req_write  in  1  1 = write, 0 = read
- f_req_addr  in  24  flash word address
- f_req_wdata  in  16  flash write data
- f_rsp_valid  out  1  one-cycle pulse: flash access complete
- f_rsp_rdata  out  16  flash read data, valid with f_rsp_valid
- s_req_valid, s_req_ready, s_req_write  in/out/in  1 each  SRAM request handshake, same semantics as flash
- s_req_addr  in  26  SRAM address
- s_req_wdata  in  32  SRAM write data
- s_rsp_valid  out  1  SRAM completion pulse
- s_rsp_rdata  out  32  SRAM read data
- fsm_a  out  26  shared address
- fsm_d_o  out  32  data driven to pads
- fsm_d_oe  out  1  pad output enable for all 32 bits
- fsm_d_i  in  32  data from pads
- flash_ce_n, flash_oe_n, flash_we_n  out  1 each  flash strobes, active-low
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low

Behaviour:
- All outputs are registered.
- Reset values: all *_n = 1; fsm_d_oe = 0; fsm_a = 0; fsm_d_o = 0; *_req_ready = 0; *_rsp_valid = 0; *_rsp_rdata = 0; rr pointer = flash.
- RST asserted mid-access:
  - next edge returns to IDLE with all strobes high and fsm_d_oe = 0;
  - no response is issued for the aborted access.
- States: IDLE, SETUP, ACCESS, HOLD, TURN.
- IDLE:
  - If any valid, grant one client: ready = 1 for exactly that cycle (handshake is valid & ready).
  - Latch write, addr and wdata; go to SETUP.
  - Requester holds its fields stable until it sees ready. ready is never high outside IDLE.
- Arbitration:
  - 2-way round robin; the pointer moves to the non-granted client after each grant.
  - When only one client is valid, that client is granted regardless of the pointer.
- SETUP (1 cycle):
  - fsm_a driven: flash uses {2'b00, f_req_addr}, SRAM uses s_req_addr.
  - Selected ce_n = 0.
  - For writes: fsm_d_oe = 1; fsm_d_o = wdata (flash: upper 16 bits = 0).
- ACCESS (WS+1 cycles, counted by a 4-bit down-counter):
  - Reads: oe_n = 0. Writes: we_n = 0.
  - Read data from fsm_d_i is sampled on the last ACCESS cycle. Flash takes bits [15:0].
- HOLD (1 cycle):
  - oe_n and we_n go back to 1; ce_n, fsm_a and the write data are held.
  - The granted client's rsp_valid = 1 for this cycle, with rdata (reads) or an ack (writes).
- TURN (TURN_CYC cycles): all ce_n = 1, fsm_d_oe = 0; then IDLE.
- Latency, measured from the accept cycle T to rsp_valid: WS+3 cycles.
  - Flash default: T+10.
  - Next accept no earlier than T+WS+4+TURN_CYC.
- Invariants:
  - flash_ce_n and sram_ce_n are never both low.
  - fsm_d_oe = 1 only during a write's SETUP, ACCESS and HOLD.
  - oe_n and we_n are never both low.
- rdata holds its last value between responses.

Decomposition:
- Shared package fsm_bus_pkg:
  - state enum
  - constants FSM_AW = 26, FSM_DW = 32, FLASH_DW = 16, FLASH_AW = 24
  - client-id enum {CL_FLASH, CL_SRAM}
- One sub-module, fsm_rr_arb: 2-input round-robin grant with a pointer register. Inputs: CLK, RST, two valids, an advance strobe. Output: one-hot grant.

Test Plan:
- Reset, then a flash read at 0x000123 with fsm_d_i = 0xDEAD_BEEF:
  - fsm_a = 0x0000123 from T+1;
  - flash_oe_n low for 8 cycles;
  - f_rsp_valid at T+10 with rdata = 0xBEEF;
  - next accept possible at T+12.
- SRAM write to 0x3FFFFFF with data 0xA5A5_5A5A:
  - sram_we_n low for 2 cycles (T+2, T+3);
  - fsm_d_oe high T+1..T+4;
  - s_rsp_valid at T+4;
  - fsm_d_oe = 0 at T+5.
- Both clients valid continuously for 6 accesses:
  - grants alternate flash, SRAM, flash, ...;
  - ce_n never both low;
  - a TURN cycle with all strobes high separates every pair of accesses.
- Only SRAM valid while the pointer is at flash: SRAM is granted immediately with no idle cycle.
- RST pulsed during a flash ACCESS cycle:
  - next cycle all strobes high and fsm_d_oe = 0;
  - no f_rsp_valid;
  - the following request completes normally.
- Build with TURN_CYC = 0 and SRAM_WS = 0: back-to-back SRAM reads accepted every 4 cycles, with rsp_valid 3 cycles after each accept.
